latch_enable_ctrl: RTL and testbench

LATCH_ENABLE_CTRL -- requirements
Module: latch_enable_ctrl

---
 rtl/latch_enable_ctrl.sv | 105 ++++++++++
 tb/tb_latch_enable_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_enable_ctrl.sv
// latch_enable_ctrl: setup / enable-pulse / hold sequencer for a
// transparent-latch bank, with complementary enables and a completion ACK.
module latch_enable_ctrl #(
    parameter int W         = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ,
    input  logic [W-1:0] DIN,
    output logic [W-1:0] D,
    output logic         EN,
    output logic         ENB,
    output logic         BUSY,
    output logic         ACK,
    inout  wire          VDD,
    inout  wire          VSS
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t     state;
    logic [3:0] cnt;

    // Rails exist only for netlist connectivity.
    wire unused_rails = VDD ^ VSS;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            D     <= '0;
            EN    <= 1'b0;
            ENB   <= 1'b1;
            ACK   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (REQ) begin
                        D     <= DIN;
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                        BUSY  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= OPEN;
                        EN    <= 1'b1;
                        ENB   <= 1'b0;
                        cnt   <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                OPEN: begin
                    if (cnt == 4'd0) begin
                        state <= HOLD;
                        EN    <= 1'b0;
                        ENB   <= 1'b1;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        ACK   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ACK   <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    // Unreachable encodings fall back to a safe idle.
                    state <= IDLE;
                    cnt   <= '0;
                    EN    <= 1'b0;
                    ENB   <= 1'b1;
                    ACK   <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_enable_ctrl.sv
// Scoreboard bench for latch_enable_ctrl: three instances with
// default, short-pulse and maximum timing parameters.
module tb_latch_enable_ctrl;

    localparam int N = 3;
    localparam int SS [N] = '{1, 3, 15};
    localparam int PP [N] = '{2, 1, 15};
    localparam int HH [N] = '{1, 2, 15};

    typedef struct {
        int         acc;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req  [N];
    logic [7:0] din  [N];
    logic [7:0] dq   [N];
    logic       en   [N];
    logic       enb  [N];
    logic       busy [N];
    logic       ack  [N];
    wire        vdd;
    wire        vss;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    exp_t sb [N][$];

    logic       en_prev  [N];
    logic       ack_prev [N];
    logic [7:0] d_en     [N];
    int         en_rise  [N];
    int         en_fall  [N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        latch_enable_ctrl #(
            .W         (8),
            .SETUP_CYC (SS[g]),
            .PULSE_CYC (PP[g]),
            .HOLD_CYC  (HH[g])
        ) u_dut (
            .CLK  (clk),
            .RST  (rst),
            .REQ  (req[g]),
            .DIN  (din[g]),
            .D    (dq[g]),
            .EN   (en[g]),
            .ENB  (enb[g]),
            .BUSY (busy[g]),
            .ACK  (ack[g]),
            .VDD  (vdd),
            .VSS  (vss)
        );
    end

    task automatic check_eq(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fails++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d",
                     nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard pops on ACK.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            check_eq("en_enb_complement", int'(en[i] ^ enb[i]), 1);
            if (!rst) begin
                if (en[i] && en_prev[i])
                    check_eq("d_stable_en", int'(dq[i]), int'(d_en[i]));
                if (en[i] && !en_prev[i]) begin
                    en_rise[i] = cyc;
                    d_en[i]    = dq[i];
                end
                if (!en[i] && en_prev[i])
                    en_fall[i] = cyc;
                if (sb[i].size() != 0 && cyc == sb[i][0].acc) begin
                    check_eq("busy_start", int'(busy[i]), 1);
                    check_eq("d_capture", int'(dq[i]), int'(sb[i][0].d));
                end
                if (ack[i]) begin
                    check_eq("ack_width", int'(ack_prev[i]), 0);
                    check_eq("ack_expected", int'(sb[i].size() != 0), 1);
                    if (sb[i].size() != 0) begin
                        e = sb[i].pop_front();
                        check_eq("ack_cycle", cyc,
                                 e.acc + SS[i] + PP[i] + HH[i]);
                        check_eq("en_rise_cycle", en_rise[i], e.acc + SS[i]);
                        check_eq("en_fall_cycle", en_fall[i],
                                 e.acc + SS[i] + PP[i]);
                        check_eq("d_at_ack", int'(dq[i]), int'(e.d));
                        check_eq("busy_at_ack", int'(busy[i]), 1);
                    end
                end
                if (ack_prev[i] && !ack[i])
                    check_eq("busy_end", int'(busy[i]), 0);
            end
            en_prev[i]  = en[i];
            ack_prev[i] = ack[i];
        end
    end

    // Single transaction on instance i; returns once the DUT is idle again.
    task automatic issue(input int i, input logic [7:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        req[i] = 1'b1;
        din[i] = v;
        e.acc  = cyc + 1;
        e.d    = v;
        sb[i].push_back(e);
        @(posedge clk);
        #1;
        req[i] = 1'b0;
        din[i] = ~v;
        repeat (SS[i] + PP[i] + HH[i] + 1) @(posedge clk);
    endtask

    initial begin
        exp_t e;
        int   a;
        for (int i = 0; i < N; i++) begin
            req[i]      = 1'b0;
            din[i]      = 8'h00;
            en_prev[i]  = 1'b0;
            ack_prev[i] = 1'b0;
            d_en[i]     = 8'h00;
            en_rise[i]  = -1;
            en_fall[i]  = -1;
        end
        req[0] = 1'b1;
        din[0] = 8'hEE;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_eq("rst_d", int'(dq[i]), 0);
            check_eq("rst_en", int'(en[i]), 0);
            check_eq("rst_enb", int'(enb[i]), 1);
            check_eq("rst_ack", int'(ack[i]), 0);
            check_eq("rst_busy", int'(busy[i]), 0);
        end
        req[0] = 1'b0;
        rst    = 1'b0;

        issue(0, 8'hA5);
        issue(0, 8'h00);
        issue(0, 8'hFF);

        // REQ held high: second capture only after returning to IDLE.
        @(posedge clk);
        #1;
        req[0] = 1'b1;
        din[0] = 8'h3C;
        a      = cyc + 1;
        e.acc  = a;
        e.d    = 8'h3C;
        sb[0].push_back(e);
        e.acc  = a + SS[0] + PP[0] + HH[0] + 2;
        e.d    = 8'h5A;
        sb[0].push_back(e);
        @(posedge clk);
        #1;
        din[0] = 8'h5A;
        repeat (SS[0] + PP[0] + HH[0] + 2) @(posedge clk);
        #1;
        req[0] = 1'b0;
        din[0] = 8'h11;
        repeat (SS[0] + PP[0] + HH[0] + 1) @(posedge clk);

        issue(1, 8'h81);
        issue(2, 8'h7E);

        // Abort in OPEN: reset at accept+2 must leave no ACK.
        @(posedge clk);
        #1;
        req[0] = 1'b1;
        din[0] = 8'h96;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_pre_en", int'(en[0]), 1);
        check_eq("abort_pre_d", int'(dq[0]), 8'h96);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_en", int'(en[0]), 0);
        check_eq("abort_enb", int'(enb[0]), 1);
        check_eq("abort_d", int'(dq[0]), 0);
        check_eq("abort_busy", int'(busy[0]), 0);
        check_eq("abort_ack", int'(ack[0]), 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check_eq("abort_stays_idle", int'(busy[0]), 0);

        issue(0, 8'h42);
        issue(1, 8'h01);

        repeat (5) @(posedge clk);
        for (int i = 0; i < N; i++)
            check_eq("sb_drained", sb[i].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
